// File: rtl/seq_pkg.sv
// Shared state encoding and length helper for the sequence detectors and the pattern generator.
package seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_e;

    // A zero or oversized length means "use the whole pattern register".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if ((len == 32'd0) || (len > max_len)) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable down-counting bit selector: presents the bit to emit next and whether it closes a repetition.
module seq_shift_reg #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             bit_out,
    output logic             last_out
);

    logic [PAT_W-1:0] pat_r;
    logic [IDX_W-1:0] top_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] load_top_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [PAT_W-1:0] sel_pat_s;

    // Index after idx; wraps to the MSB of the active field for the next repetition.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [IDX_W-1:0] top);
        if (idx == {IDX_W{1'b0}}) begin
            return top;
        end else begin
            return idx - IDX_W'(1'b1);
        end
    endfunction

    assign load_top_s = IDX_W'(len - LEN_W'(1'b1));

    // On load the first bit comes straight from the inputs so it can be registered on the same edge.
    always_comb begin
        sel_idx_s = idx_r;
        sel_pat_s = pat_r;
        if (load) begin
            sel_idx_s = load_top_s;
            sel_pat_s = pattern;
        end else begin
            sel_idx_s = idx_r;
            sel_pat_s = pat_r;
        end
    end

    assign bit_out  = sel_pat_s[sel_idx_s];
    assign last_out = (sel_idx_s == {IDX_W{1'b0}});

    // Pattern latch and down-counting index, pointing at the bit for the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= {PAT_W{1'b0}};
            top_r <= {IDX_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (load) begin
            pat_r <= pattern;
            top_r <= load_top_s;
            idx_r <= next_idx(load_top_s, load_top_s);
        end else if (advance) begin
            idx_r <= next_idx(idx_r, top_r);
        end
    end

endmodule

// File: rtl/mealy_seq_pattern_gen.sv
// Bit-serial pattern transmitter feeding the sequence detectors; GAP_EN adds idle gaps between repetitions.
module mealy_seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
`ifdef GAP_EN
    ,
    parameter int GAP_W = 4
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PAT_W-1:0]       pattern,
    input  logic [$clog2(PAT_W):0] pat_len,
    input  logic [CNT_W-1:0]       rep_cnt,
`ifdef GAP_EN
    input  logic [GAP_W-1:0]       gap_len,
`endif
    output logic                   busy,
    output logic                   dout,
    output logic                   dout_valid,
    output logic                   bit_last,
    output logic                   done,
    output logic [CNT_W-1:0]       reps_sent
);

    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    state_e           state_r;
    logic             busy_r;
    logic             dout_r;
    logic             dout_valid_r;
    logic             bit_last_r;
    logic             done_r;
    logic [CNT_W-1:0] reps_sent_r;
    logic [CNT_W-1:0] rep_cnt_r;
`ifdef GAP_EN
    logic [GAP_W-1:0] gap_len_r;
    logic [GAP_W-1:0] gap_cnt_r;
`endif

    logic [LEN_W-1:0] len_s;
    logic             load_s;
    logic             advance_s;
    logic             bit_s;
    logic             last_s;
    logic             rep_end_s;
    logic             gap_next_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    assign len_s = LEN_W'(clamp_len(32'(pat_len), unsigned'(PAT_W)));

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .IDX_W (IDX_W)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .advance  (advance_s),
        .pattern  (pattern),
        .len      (len_s),
        .bit_out  (bit_s),
        .last_out (last_s)
    );

    // Decide whether the next edge loads a new burst or steps to the next bit.
    always_comb begin
        load_s     = 1'b0;
        advance_s  = 1'b0;
        rep_end_s  = bit_last_r && (reps_sent_r == rep_cnt_r);
`ifdef GAP_EN
        gap_next_s = bit_last_r && (gap_len_r != {GAP_W{1'b0}});
`else
        gap_next_s = 1'b0;
`endif
        case (state_r)
            IDLE: load_s = start && !abort && (rep_cnt != {CNT_W{1'b0}});
            SEND: advance_s = !abort && !rep_end_s && !gap_next_s;
`ifdef GAP_EN
            GAP:  advance_s = !abort && (gap_cnt_r == GAP_W'(1'b1));
`endif
            default: begin
                load_s    = 1'b0;
                advance_s = 1'b0;
            end
        endcase
    end

    // Burst FSM with registered outputs; outputs always describe the cycle after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            bit_last_r   <= 1'b0;
            done_r       <= 1'b0;
            reps_sent_r  <= {CNT_W{1'b0}};
            rep_cnt_r    <= {CNT_W{1'b0}};
`ifdef GAP_EN
            gap_len_r    <= {GAP_W{1'b0}};
            gap_cnt_r    <= {GAP_W{1'b0}};
`endif
        end else if (abort && (state_r != IDLE)) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            bit_last_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dout_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    bit_last_r   <= 1'b0;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    if (start && !abort) begin
                        rep_cnt_r   <= rep_cnt;
                        reps_sent_r <= {CNT_W{1'b0}};
`ifdef GAP_EN
                        gap_len_r   <= gap_len;
`endif
                        if (rep_cnt == {CNT_W{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r      <= SEND;
                            busy_r       <= 1'b1;
                            dout_r       <= bit_s;
                            dout_valid_r <= 1'b1;
                            bit_last_r   <= last_s;
                            reps_sent_r  <= last_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
                        end
                    end
                end
                SEND: begin
                    if (rep_end_s) begin
                        state_r      <= DONE;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        dout_r       <= 1'b0;
                        dout_valid_r <= 1'b0;
                        bit_last_r   <= 1'b0;
`ifdef GAP_EN
                    end else if (gap_next_s) begin
                        state_r      <= GAP;
                        gap_cnt_r    <= gap_len_r;
                        dout_r       <= 1'b0;
                        dout_valid_r <= 1'b0;
                        bit_last_r   <= 1'b0;
`endif
                    end else begin
                        dout_r       <= bit_s;
                        dout_valid_r <= 1'b1;
                        bit_last_r   <= last_s;
                        if (last_s) begin
                            reps_sent_r <= sat_inc(reps_sent_r);
                        end
                    end
                end
`ifdef GAP_EN
                GAP: begin
                    if (gap_cnt_r == GAP_W'(1'b1)) begin
                        state_r      <= SEND;
                        dout_r       <= bit_s;
                        dout_valid_r <= 1'b1;
                        bit_last_r   <= last_s;
                        if (last_s) begin
                            reps_sent_r <= sat_inc(reps_sent_r);
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1'b1);
                    end
                end
`endif
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    dout_r       <= 1'b0;
                    dout_valid_r <= 1'b0;
                    bit_last_r   <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign bit_last   = bit_last_r;
    assign done       = done_r;
    assign reps_sent  = reps_sent_r;

endmodule

// File: tb/tb_mealy_seq_pattern_gen.sv
// Self-checking bench for mealy_seq_pattern_gen: vector table, hand-written corner sequences, random bursts.
module tb_mealy_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [7:0] rep_cnt;
`ifdef GAP_EN
    logic [3:0] gap_len;
`endif
    logic       busy;
    logic       dout;
    logic       dout_valid;
    logic       bit_last;
    logic       done;
    logic [7:0] reps_sent;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mealy_seq_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .rep_cnt    (rep_cnt),
`ifdef GAP_EN
        .gap_len    (gap_len),
`endif
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .bit_last   (bit_last),
        .done       (done),
        .reps_sent  (reps_sent)
    );

    typedef struct {
        logic v;
        logic b;
        logic l;
        int   reps;
    } cyc_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        int         reps;
        int         gap;
        int         exp_bits;
        int         exp_reps;
    } vec_t;

    cyc_t exp_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected cycle stream straight from the rules: repetitions of the MSB-first field, gaps between.
    function automatic void build_model(input logic [7:0] pat, input logic [3:0] len,
                                        input int reps, input int gap);
        int L;
        int n;
        int eff_gap;
`ifdef GAP_EN
        eff_gap = gap;
`else
        eff_gap = 0 * gap;
`endif
        exp_q.delete();
        L = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
        n = 0;
        for (int r = 0; r < reps; r++) begin
            for (int i = L - 1; i >= 0; i--) begin
                if (i == 0) n++;
                exp_q.push_back('{1'b1, pat[i], (i == 0), n});
            end
            if (r < reps - 1) begin
                for (int g = 0; g < eff_gap; g++) exp_q.push_back('{1'b0, 1'b0, 1'b0, n});
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [7:0] pat, input logic [3:0] len, input int reps,
                             input int gap, output int nbits, output int final_reps);
        int exp_final;
        build_model(pat, len, reps, gap);
        exp_final = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1].reps : 0;
        pattern = pat;
        pat_len = len;
        rep_cnt = reps[7:0];
`ifdef GAP_EN
        gap_len = gap[3:0];
`endif
        start = 1'b1;
        step();
        nbits = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check("dout_valid", int'(dout_valid), int'(exp_q[k].v));
            check("dout", int'(dout), int'(exp_q[k].b));
            check("bit_last", int'(bit_last), int'(exp_q[k].l));
            check("busy_in_burst", int'(busy), 1);
            check("done_in_burst", int'(done), 0);
            check("reps_sent", int'(reps_sent), exp_q[k].reps);
            if (dout_valid === 1'b1) nbits++;
            // Mid-burst input changes and stray starts must be ignored.
            start   = 1'($urandom_range(0, 1));
            pattern = 8'($urandom);
            pat_len = 4'($urandom);
            rep_cnt = 8'($urandom);
`ifdef GAP_EN
            gap_len = 4'($urandom);
`endif
            step();
        end
        check("done_pulse", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        check("valid_at_done", int'(dout_valid), 0);
        check("reps_at_done", int'(reps_sent), exp_final);
        final_reps = int'(reps_sent);
        start = 1'b0;
        step();
        check("done_cleared", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("valid_idle", int'(dout_valid), 0);
    endtask

    initial begin
        int nb;
        int fr;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'h00;
        pat_len = 4'd0;
        rep_cnt = 8'd0;
`ifdef GAP_EN
        gap_len = 4'd0;
`endif
        vecs[0] = '{8'h0A, 4'd4,  3, 0, 12, 3};
        vecs[1] = '{8'hFF, 4'd4,  0, 2, 0,  0};
        vecs[2] = '{8'hA5, 4'd0,  1, 0, 8,  1};
        vecs[3] = '{8'h3C, 4'd12, 2, 1, 16, 2};
        vecs[4] = '{8'h01, 4'd1,  5, 2, 5,  5};
        vecs[5] = '{8'h96, 4'd8,  2, 0, 16, 2};
        vecs[6] = '{8'h01, 4'd1,  255, 0, 255, 255};

        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_last", int'(bit_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_reps", int'(reps_sent), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i].pat, vecs[i].len, vecs[i].reps, vecs[i].gap, nb, fr);
            check("tbl_bits", nb, vecs[i].exp_bits);
            check("tbl_reps", fr, vecs[i].exp_reps);
        end

        // Abort on the 6th bit of the basic burst.
        pattern = 8'h0A; pat_len = 4'd4; rep_cnt = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("abort_bit6", int'(dout), 0);
        check("abort_reps_pre", int'(reps_sent), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", int'(dout_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_reps_hold", int'(reps_sent), 1);
        for (int k = 0; k < 8; k++) begin
            check("abort_no_done", int'(done), 0);
            check("abort_quiet", int'(dout_valid), 0);
            step();
        end

        // start and abort together in IDLE: abort wins.
        pattern = 8'hFF; pat_len = 4'd2; rep_cnt = 8'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", int'(busy), 0);
        check("startabort_valid", int'(dout_valid), 0);
        step();
        check("startabort_done", int'(done), 0);

        // Synchronous reset mid-burst, then a clean restart.
        pattern = 8'h0A; pat_len = 4'd4; rep_cnt = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("prereset_reps", int'(reps_sent), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", int'(dout_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_dout", int'(dout), 0);
        check("midrst_reps", int'(reps_sent), 0);
        run_burst(8'h0A, 4'd4, 3, 0, nb, fr);
        check("restart_bits", nb, 12);

`ifdef GAP_EN
        run_burst(8'h0A, 4'd4, 2, 3, nb, fr);
        check("gap_bits", nb, 8);
        check("gap_reps", fr, 2);
`endif

        for (int i = 0; i < 20; i++) begin
            run_burst(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), nb, fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealy_seq_pattern_gen.md
Name: mealy_seq_pattern_gen

Overview:
Bit-serial pattern transmitter that drives the serial input of the team's sequence-detector FSMs.
- Latches a pattern of up to PAT_W bits, a length and a repeat count, then shifts the pattern out MSB-first, one bit per clock, the requested number of times.
- Sits opposite the Mealy/Moore detectors in self-checking benches and in on-chip loopback: dout here feeds din there.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, width of the repeat count and of reps_sent
GAP_W, 4, width of the inter-repetition gap length (used only with GAP_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  request a new burst; sampled only in IDLE
abort  input  1  terminate the burst at once; no done pulse
pattern  input  PAT_W  bits to send; active field is pattern[len-1:0]
pat_len  input  $clog2(PAT_W)+1  number of bits per repetition
rep_cnt  input  CNT_W  number of repetitions
gap_len  input  GAP_W  idle zeros between repetitions (GAP_EN only)
busy  output  1  high from the cycle after start is accepted until DONE exits
dout  output  1  serial data, registered
dout_valid  output  1  dout carries a pattern bit this cycle
bit_last  output  1  high with the final bit of each repetition
done  output  1  one-cycle pulse when the burst completes
reps_sent  output  CNT_W  repetitions completed in the current or last burst

Behaviour:
- All outputs are registered. Reset values: busy=0, dout=0, dout_valid=0, bit_last=0, done=0, reps_sent=0. State returns to IDLE.
- States:
  - IDLE: start=1 latches pattern, pat_len and rep_cnt (and gap_len), clears reps_sent, then goes to SEND. start is ignored in every other state.
  - SEND: outputs one bit per cycle, MSB-first starting at pattern[len-1], with dout_valid=1.
    - The first bit is visible on the cycle after start is accepted, i.e. 1-cycle latency.
    - Bit index counts down. At index 0: bit_last=1 and reps_sent increments in that same cycle.
    - After the final bit: if more repetitions remain, the next repetition starts in the immediately following cycle (back-to-back, no bubble). Otherwise go to DONE.
  - GAP: exists only with GAP_EN; see Optional Feature.
  - DONE: one cycle with done=1 and busy=0, then IDLE. A start arriving in the DONE cycle is ignored.
- Outside SEND: dout=0, dout_valid=0, bit_last=0.
- Boundary conditions:
  - pat_len=0 or pat_len>PAT_W: length is clamped to PAT_W.
  - rep_cnt=0: IDLE goes to DONE directly. No bits are sent, done pulses on the cycle after start, reps_sent=0.
  - reps_sent saturates at 2^CNT_W-1. It cannot exceed rep_cnt in any case.
  - Inputs changing mid-burst have no effect; only the latched copies are used.
  - abort (any state except IDLE): next cycle is IDLE, all outputs 0 except reps_sent, which holds its value. No done pulse. abort has priority over completion in the same cycle.
  - reset mid-burst: behaves like abort, but also clears reps_sent. reset has priority over abort and start.
  - start and abort both high in IDLE: abort wins and the start is dropped.

Optional Feature:
GAP_EN
- Defined:
  - After each repetition except the last, enter GAP for the latched gap_len cycles with dout=0, dout_valid=0 and busy=1, then return to SEND.
  - gap_len=0 gives back-to-back repetitions, identical to the non-GAP_EN case.
  - This lets benches exercise non-overlapping detection with idle separators.
- Not defined: the GAP state, the gap counter and the gap_len port are all removed. Repetitions are always back-to-back.

Decomposition:
- Shared package seq_pkg holds:
  - typedef state_e {IDLE, SEND, GAP, DONE};
  - localparam encodings;
  - the helper function clamp_len.
- The detectors already use this package for their own states.
- Natural sub-module: seq_shift_reg, a loadable down-counting bit selector that produces the current bit and a last flag. The top FSM owns repetition, gap and handshake logic.

Test Plan:
- Basic burst: pattern=8'h0A, pat_len=4, rep_cnt=3 -> dout = 1,0,1,0 repeated 3 times over 12 consecutive cycles starting 1 cycle after start; bit_last high on bits 4, 8 and 12; done 1 cycle after bit 12; reps_sent=3.
- Zero reps: rep_cnt=0, start -> done on the next cycle, dout_valid never high, reps_sent=0.
- Length clamp: pat_len=0, pattern=8'hA5, rep_cnt=1 -> 8 bits 1,0,1,0,0,1,0,1 then done.
- Abort: abort asserted on the 6th bit of the basic burst -> dout_valid drops the next cycle, no done pulse, reps_sent holds 1.
- Reset and restart: synchronous reset mid-burst -> all outputs 0 on the next edge; a following start runs a clean burst from bit 1.
- GAP_EN: pattern=4'b1010, rep_cnt=2, gap_len=3 -> 1,0,1,0, then 3 invalid zero cycles, then 1,0,1,0, then done. Loopback into the nonoverlapping detector gives exactly 2 dout pulses.
